// File: rtl/scroll_world.sv
// Side-scroller world engine: obstacle field, LFSR generator, jump physics, score.
// Optional macro SCROLL_WORLD_LIVES_EN enables multiple lives per run.
module scroll_world #(
    parameter int COLS = 80,
    parameter int HW = 2,
    parameter int RATE_W = 28,
    parameter int GAP_MIN = 4,
    parameter logic [15:0] SEED = 16'hACE1,
    parameter int LIVES = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 go,
    input  logic                 stop,
    input  logic                 jump,
    input  logic [RATE_W-1:0]    rate,
    output logic [COLS*HW-1:0]   field,
    output logic [HW-1:0]        runner_h,
    output logic [1:0]           state,
    output logic                 tick,
    output logic                 hit,
    output logic [15:0]          score,
    output logic [1:0]           lives
);

    localparam int FW = COLS * HW;
    localparam logic [HW-1:0] HMAX = '1;
    localparam logic [7:0] GAP_LIM = 8'(GAP_MIN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_OVER = 2'd2;

`ifdef SCROLL_WORLD_LIVES_EN
    localparam bit LIVES_ON = 1'b1;
`else
    localparam bit LIVES_ON = 1'b0;
`endif
    localparam logic [1:0] LIVES_INIT = LIVES_ON ? 2'(LIVES) : 2'd0;

    logic [1:0]        state_q, state_d;
    logic [FW-1:0]     field_q, field_d;
    logic [HW-1:0]     runner_q, runner_d;
    logic              dir_q, dir_d;
    logic              tick_q, tick_d;
    logic              hit_q, hit_d;
    logic [15:0]       score_q, score_d;
    logic [1:0]        lives_q, lives_d;
    logic [RATE_W-1:0] count_q, count_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [7:0]        gap_q, gap_d;
    logic              jlat_q, jlat_d;

    logic              jump_set;
    logic              clr;
    logic [HW-1:0]     new_col;
    logic [HW-1:0]     col1;
    logic [7:0]        gap_n;
    logic [15:0]       lfsr_n;
    logic [HW-1:0]     runner_n;
    logic              dir_n;
    logic              collide;

    assign jump_set = jlat_q | jump;
    assign col1 = field_q[FW-HW-1 -: HW];
    assign lfsr_n = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                     lfsr_q[15:1]};

    // Next obstacle column and gap counter for a step.
    always_comb begin
        new_col = '0;
        gap_n = (gap_q == 8'hFF) ? gap_q : gap_q + 8'd1;
        if (gap_q >= GAP_LIM && lfsr_q[0]) begin
            new_col = lfsr_q[HW:1];
            if (new_col == '0) begin
                new_col = HW'(1);
            end
            gap_n = 8'd0;
        end
    end

    always_comb begin
        runner_n = runner_q;
        dir_n = dir_q;
        if (runner_q == '0 && jump_set) begin
            runner_n = HW'(1);
            dir_n = 1'b1;
        end else if (runner_q != '0 && dir_q) begin
            if (runner_q == HMAX) begin
                dir_n = 1'b0;
                runner_n = runner_q - 1'b1;
            end else begin
                runner_n = runner_q + 1'b1;
            end
        end else if (runner_q != '0) begin
            runner_n = runner_q - 1'b1;
        end
    end

    assign collide = col1 > runner_n;

    // Any stop, every IDLE cycle and a restart from OVER all reload the
    // idle values, which hides any step computed in the same cycle.
    assign clr = stop || (state_q == S_IDLE) || (state_q == S_OVER && go);

    always_comb begin
        state_d = state_q;
        field_d = field_q;
        runner_d = runner_q;
        dir_d = dir_q;
        tick_d = 1'b0;
        hit_d = 1'b0;
        score_d = score_q;
        lives_d = lives_q;
        count_d = count_q;
        lfsr_d = lfsr_q;
        gap_d = gap_q;
        jlat_d = jlat_q;
        if (clr) begin
            state_d = (state_q == S_IDLE && go && !stop) ? S_RUN : S_IDLE;
            field_d = '0;
            runner_d = '0;
            dir_d = 1'b1;
            score_d = '0;
            lives_d = LIVES_INIT;
            count_d = rate;
            lfsr_d = SEED;
            gap_d = '0;
            jlat_d = 1'b0;
        end else if (state_q == S_RUN) begin
            jlat_d = jump_set;
            count_d = count_q - 1'b1;
            if (count_q == '0) begin
                count_d = rate;
                jlat_d = 1'b0;
                tick_d = 1'b1;
                field_d = {field_q[FW-HW-1:0], new_col};
                gap_d = gap_n;
                lfsr_d = lfsr_n;
                runner_d = runner_n;
                dir_d = dir_n;
                if (collide) begin
                    hit_d = 1'b1;
                    if (LIVES_ON && lives_q > 2'd1) begin
                        lives_d = lives_q - 2'd1;
                        field_d[FW-1 -: HW] = '0;
                    end else begin
                        lives_d = 2'd0;
                        state_d = S_OVER;
                    end
                end else if (score_q != 16'hFFFF) begin
                    score_d = score_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            field_q <= '0;
            runner_q <= '0;
            dir_q <= 1'b1;
            tick_q <= 1'b0;
            hit_q <= 1'b0;
            score_q <= '0;
            lives_q <= '0;
            count_q <= '0;
            lfsr_q <= SEED;
            gap_q <= '0;
            jlat_q <= 1'b0;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            runner_q <= runner_d;
            dir_q <= dir_d;
            tick_q <= tick_d;
            hit_q <= hit_d;
            score_q <= score_d;
            lives_q <= lives_d;
            count_q <= count_d;
            lfsr_q <= lfsr_d;
            gap_q <= gap_d;
            jlat_q <= jlat_d;
        end
    end

    assign field = field_q;
    assign runner_h = runner_q;
    assign state = state_q;
    assign tick = tick_q;
    assign hit = hit_q;
    assign score = score_q;
    assign lives = lives_q;

endmodule

// File: tb/tb_scroll_world.sv
// Directed bench for scroll_world: timing, jump arc, field generator, collision.
// Build with SCROLL_WORLD_LIVES_EN to also exercise the lives path.
module tb_scroll_world;

    localparam int COLS = 80;
    localparam int HW = 2;
    localparam int RATE_W = 28;
    localparam int FW = COLS * HW;
`ifdef SCROLL_WORLD_LIVES_EN
    localparam int LIV0 = 3;
`else
    localparam int LIV0 = 0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic go = 1'b0;
    logic stop = 1'b0;
    logic jump = 1'b0;
    logic [RATE_W-1:0] rate = '0;
    logic [FW-1:0] field;
    logic [HW-1:0] runner_h;
    logic [1:0] state;
    logic tick;
    logic hit;
    logic [15:0] score;
    logic [1:0] lives;

    int errs = 0;
    int checks = 0;

    logic [15:0] mlfsr;
    int mgap;
    int mcol[COLS];
    int mscore;
    int mlives;

    scroll_world dut (
        .clk(clk), .resetn(resetn), .go(go), .stop(stop),
        .jump(jump), .rate(rate), .field(field),
        .runner_h(runner_h), .state(state), .tick(tick),
        .hit(hit), .score(score), .lives(lives)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [FW-1:0] got,
                       input logic [FW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 100);
        chk("tick_seen", FW'(tick), 1);
    endtask

    function automatic logic [FW-1:0] pack_model();
        logic [FW-1:0] v;
        v = '0;
        for (int c = 0; c < COLS; c++)
            v[(COLS-c)*HW-1 -: HW] = HW'(mcol[c]);
        return v;
    endfunction

    function automatic int gap_violations(input logic [FW-1:0] f);
        int last;
        int bad;
        last = -100;
        bad = 0;
        for (int c = 0; c < COLS; c++) begin
            if (f[(COLS-c)*HW-1 -: HW] != '0) begin
                if (c - last < 5) bad++;
                last = c;
            end
        end
        return bad;
    endfunction

    task automatic model_reset();
        mlfsr = 16'hACE1;
        mgap = 0;
        mscore = 0;
        mlives = LIV0;
        for (int c = 0; c < COLS; c++) mcol[c] = 0;
    endtask

    // Reference step with a stationary runner at height 0.
    task automatic model_step(output bit mhit, output bit mover);
        int nc;
        logic [HW-1:0] h;
        nc = 0;
        if (mgap >= 4 && mlfsr[0]) begin
            h = mlfsr[HW:1];
            nc = (h == 0) ? 1 : int'(h);
            mgap = 0;
        end else if (mgap < 255) begin
            mgap++;
        end
        mlfsr = {mlfsr[0] ^ mlfsr[2] ^ mlfsr[3] ^ mlfsr[5], mlfsr[15:1]};
        for (int c = 0; c < COLS - 1; c++) mcol[c] = mcol[c+1];
        mcol[COLS-1] = nc;
        mhit = mcol[0] > 0;
        mover = 1'b0;
        if (mhit) begin
            if (mlives > 1) begin
                mlives--;
                mcol[0] = 0;
            end else begin
                mlives = 0;
                mover = 1'b1;
            end
        end else if (mscore < 65535) begin
            mscore++;
        end
    endtask

    initial begin
        int n;
        int bad;
        bit mh;
        bit mo;
        bit done;
        logic [FW-1:0] fs;
        logic [15:0] sc;
        int jseq[6] = '{1, 2, 3, 2, 1, 0};
        int hseq[7] = '{1, 2, 3, 2, 1, 0, 1};

        resetn = 1'b0;
        rate = 3;
        repeat (2) @(negedge clk);
        chk("rst_state", FW'(state), 0);
        chk("rst_field", field, 0);
        chk("rst_runner", FW'(runner_h), 0);
        chk("rst_tick", FW'(tick), 0);
        chk("rst_hit", FW'(hit), 0);
        chk("rst_score", FW'(score), 0);
        chk("rst_lives", FW'(lives), 0);

        resetn = 1'b1;
        go = 1'b1;
        @(negedge clk);
        chk("run_entry", FW'(state), 1);
        go = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            wait_tick(n);
            chk("tick_period", FW'(n), 4);
            chk("score_inc", FW'(score), FW'(i));
        end

        @(negedge clk);
        jump = 1'b1;
        @(negedge clk);
        jump = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wait_tick(n);
            chk("jump_arc", FW'(runner_h), FW'(jseq[i]));
        end
        jump = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wait_tick(n);
            chk("jump_held", FW'(runner_h), FW'(hseq[i]));
            chk("jump_nohit", FW'(hit), 0);
        end
        jump = 1'b0;
        chk("score_16", FW'(score), 16);

        stop = 1'b1;
        go = 1'b1;
        @(negedge clk);
        chk("stop_run", FW'(state), 0);
        chk("stop_field", field, 0);
        chk("stop_score", FW'(score), 0);
        chk("stop_runner", FW'(runner_h), 0);
        @(negedge clk);
        chk("stop_idle", FW'(state), 0);

        rate = 0;
        stop = 1'b0;
        @(negedge clk);
        chk("run_entry2", FW'(state), 1);
        go = 1'b0;
        model_reset();
        bad = 0;
        done = 1'b0;
        for (int s = 0; s < 500 && !done; s++) begin
            @(negedge clk);
            model_step(mh, mo);
            bad += gap_violations(field);
            chk("gen_field", field, pack_model());
            chk("gen_tick", FW'(tick), 1);
            chk("gen_hit", FW'(hit), FW'(mh));
            chk("gen_score", FW'(score), FW'(mscore));
            chk("gen_lives", FW'(lives), FW'(mlives));
            chk("gen_state", FW'(state), mo ? 2 : 1);
            done = mo;
        end
        chk("over_reached", FW'(done), 1);
        chk("gap_min", FW'(bad), 0);

        fs = field;
        sc = score;
        repeat (3) begin
            @(negedge clk);
            chk("over_field", field, fs);
            chk("over_score", FW'(score), FW'(sc));
            chk("over_state", FW'(state), 2);
            chk("over_tick", FW'(tick), 0);
            chk("over_hit", FW'(hit), 0);
        end

        go = 1'b1;
        @(negedge clk);
        chk("restart_idle", FW'(state), 0);
        @(negedge clk);
        chk("restart_run", FW'(state), 1);
        chk("restart_field", field, 0);
        chk("restart_score", FW'(score), 0);
        stop = 1'b1;
        @(negedge clk);
        chk("stop_go_run", FW'(state), 0);

        stop = 1'b0;
        rate = 10;
        @(negedge clk);
        chk("run_entry3", FW'(state), 1);
        go = 1'b0;
        repeat (60) @(negedge clk);
        chk("slow_score", FW'(score), 5);
        #2 resetn = 1'b0;
        #1;
        chk("async_state", FW'(state), 0);
        chk("async_field", field, 0);
        chk("async_score", FW'(score), 0);
        @(negedge clk);
        resetn = 1'b1;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
